// File: rtl/dht11_pkg.sv
// Shared state encoding, protocol timing (in microseconds) and frame helpers
// for the DHT11 sensor emulator.
package dht11_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOST_LOW,
        WAIT_RESP,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        END_LOW
    } state_t;

    localparam int WAIT_RESP_US  = 20;
    localparam int RESP_LOW_US   = 80;
    localparam int RESP_HIGH_US  = 80;
    localparam int BIT_LOW_US    = 50;
    localparam int BIT0_HIGH_US  = 27;
    localparam int BIT1_HIGH_US  = 70;
    localparam int END_LOW_US    = 50;
    localparam int FRAME_BITS    = 40;

    // Frame layout on the wire, MSB first: RH int, RH dec, T int, T dec, checksum.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] hum,
                                                          input logic [7:0] temp);
        logic [7:0] sum;
        sum = hum + temp;
        return {hum, 8'h00, temp, 8'h00, sum};
    endfunction

endpackage

// File: rtl/usec_tick_gen.sv
// Free-running divider producing a one-cycle tick every CLK_MHZ clocks (1 us).
module usec_tick_gen #(
    parameter int CLK_MHZ = 100
) (
    input  logic clk,
    input  logic reset_p,
    output logic tick
);

    localparam int CW = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(CLK_MHZ - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/dht11_sensor_emu.sv
// Emulates a DHT11 sensor on an open-drain single-wire bus: detects the host
// start pulse, answers with the response handshake and a 40-bit frame.
module dht11_sensor_emu
    import dht11_pkg::*;
#(
    parameter int CLK_MHZ      = 100,
    parameter int START_MIN_US = 18000
) (
    input  logic       clk,
    input  logic       reset_p,
    inout  wire        dht11_data,
    input  logic [7:0] humidity,
    input  logic [7:0] temperature,
    output logic       busy,
    output logic       frame_done
);

    localparam int CNT_W = ($clog2(START_MIN_US + 1) > 7) ? $clog2(START_MIN_US + 1) : 7;

    state_t                  state, next_state;
    logic [1:0]              sync_q;
    logic                    line_in;
    logic                    tick;
    logic [CNT_W-1:0]        us_cnt;
    logic [CNT_W-1:0]        dur;
    logic [FRAME_BITS-1:0]   frame;
    logic [5:0]              bit_idx;
    logic                    drive_low;
    logic                    timed_done;
    logic                    cnt_clr, cnt_inc, latch, idx_dec;
    logic                    drive_low_nxt, busy_nxt, done_nxt;

    assign dht11_data = drive_low ? 1'b0 : 1'bz;
    assign line_in    = sync_q[1];

    usec_tick_gen #(.CLK_MHZ(CLK_MHZ)) u_tick (
        .clk     (clk),
        .reset_p (reset_p),
        .tick    (tick)
    );

    // Synchronizer idles high so reset never looks like a host start.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) sync_q <= 2'b11;
        else         sync_q <= {sync_q[0], dht11_data};
    end

    always_comb begin
        dur = CNT_W'(1);
        case (state)
            WAIT_RESP: dur = CNT_W'(WAIT_RESP_US);
            RESP_LOW:  dur = CNT_W'(RESP_LOW_US);
            RESP_HIGH: dur = CNT_W'(RESP_HIGH_US);
            BIT_LOW:   dur = CNT_W'(BIT_LOW_US);
            BIT_HIGH:  dur = frame[bit_idx] ? CNT_W'(BIT1_HIGH_US) : CNT_W'(BIT0_HIGH_US);
            END_LOW:   dur = CNT_W'(END_LOW_US);
            default:   dur = CNT_W'(1);
        endcase
    end

    assign timed_done = tick && (us_cnt == dur - 1'b1);

    always_comb begin
        next_state = state;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        latch      = 1'b0;
        idx_dec    = 1'b0;
        case (state)
            IDLE: begin
                if (!line_in) begin
                    next_state = HOST_LOW;
                    cnt_clr    = 1'b1;
                end
            end
            HOST_LOW: begin
                if (line_in) begin
                    cnt_clr = 1'b1;
                    if (us_cnt >= CNT_W'(START_MIN_US)) begin
                        next_state = WAIT_RESP;
                        latch      = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end else if (tick && us_cnt < CNT_W'(START_MIN_US)) begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                // Timed states: the host line is not looked at until IDLE again.
                if (timed_done) begin
                    cnt_clr = 1'b1;
                    case (state)
                        WAIT_RESP: next_state = RESP_LOW;
                        RESP_LOW:  next_state = RESP_HIGH;
                        RESP_HIGH: next_state = BIT_LOW;
                        BIT_LOW:   next_state = BIT_HIGH;
                        BIT_HIGH: begin
                            if (bit_idx == 6'd0) begin
                                next_state = END_LOW;
                            end else begin
                                next_state = BIT_LOW;
                                idx_dec    = 1'b1;
                            end
                        end
                        END_LOW:   next_state = IDLE;
                        default:   next_state = IDLE;
                    endcase
                end else if (tick) begin
                    cnt_inc = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        drive_low_nxt = (next_state == RESP_LOW) || (next_state == BIT_LOW) ||
                        (next_state == END_LOW);
        busy_nxt      = (next_state != IDLE) && (next_state != HOST_LOW);
        done_nxt      = (state == END_LOW) && (next_state == IDLE);
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state      <= IDLE;
            us_cnt     <= '0;
            frame      <= '0;
            bit_idx    <= '0;
            drive_low  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= next_state;
            drive_low  <= drive_low_nxt;
            busy       <= busy_nxt;
            frame_done <= done_nxt;
            if (cnt_clr)      us_cnt <= '0;
            else if (cnt_inc) us_cnt <= us_cnt + 1'b1;
            if (latch) begin
                frame   <= build_frame(humidity, temperature);
                bit_idx <= 6'(FRAME_BITS - 1);
            end else if (idx_dec) begin
                bit_idx <= bit_idx - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dht11_sensor_emu.sv
// Host-side bench: issues start pulses, times the wire and decodes frames
// against checksums computed from the transmitted values.
module tb_dht11_sensor_emu;

    localparam int CLK_MHZ  = 2;
    localparam int START_US = 200;
    localparam int TOL_US   = 3;

    logic       clk = 1'b0;
    logic       reset_p;
    logic [7:0] humidity, temperature;
    logic       busy, frame_done;
    logic       host_low;
    wire        dht11_data;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    assign dht11_data = host_low ? 1'b0 : 1'bz;
    pullup (dht11_data);

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_done === 1'b1) done_cnt <= done_cnt + 1;

    dht11_sensor_emu #(.CLK_MHZ(CLK_MHZ), .START_MIN_US(START_US)) dut (
        .clk         (clk),
        .reset_p     (reset_p),
        .dht11_data  (dht11_data),
        .humidity    (humidity),
        .temperature (temperature),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    initial begin
        #950000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_near(input string tag, input int got_cyc, input int exp_us);
        logic ok;
        ok = (got_cyc >= (exp_us - TOL_US) * CLK_MHZ) && (got_cyc <= (exp_us + TOL_US) * CLK_MHZ);
        checks++;
        assert (ok === 1'b1) else begin
            failures++;
            $error("FAIL %s got=%0d cycles exp=%0d cycles", tag, got_cyc, exp_us * CLK_MHZ);
        end
    endtask

    task automatic wait_us(input int n);
        repeat (n * CLK_MHZ) @(negedge clk);
    endtask

    task automatic measure(input logic lvl, input int max_us, output int cyc);
        cyc = 0;
        while ((dht11_data === lvl) && (cyc < max_us * CLK_MHZ)) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_frame(input logic [7:0] h, input logic [7:0] t,
                            input int abort_bit, input logic glitch);
        logic [39:0] exp_f, got_f;
        int          s, c, d0;
        s     = (int'(h) + int'(t)) % 256;
        exp_f = {h, 8'h00, t, 8'h00, s[7:0]};
        got_f = '0;
        humidity    = h;
        temperature = t;
        d0 = done_cnt;
        @(negedge clk);
        host_low = 1'b1;
        wait_us(START_US + 20);
        host_low = 1'b0;
        @(negedge clk);
        measure(1'b1, 100, c); chk_near("resp_wait", c, WAIT_US());
        measure(1'b0, 150, c); chk_near("resp_low", c, 80);
        chk("busy_in_frame", int'(busy), 1);
        if (glitch) begin
            wait_us(20);
            host_low    = 1'b1;
            humidity    = ~h;
            temperature = t + 8'd1;
            wait_us(30);
            host_low = 1'b0;
            @(negedge clk);
            measure(1'b1, 150, c); chk_near("resp_high_rest", c, 30);
        end else begin
            measure(1'b1, 150, c); chk_near("resp_high", c, 80);
        end
        for (int i = 39; i >= 0; i--) begin
            if (i == abort_bit) begin
                repeat (4) @(negedge clk);
                @(posedge clk);
                #1 reset_p = 1'b1;
                #1;
                chk("abort_released", int'(dht11_data === 1'b1), 1);
                chk("abort_busy", int'(busy), 0);
                wait_us(5);
                reset_p = 1'b0;
                measure(1'b1, 300, c); chk("abort_quiet", c, 300 * CLK_MHZ);
                chk("abort_no_done", done_cnt - d0, 0);
                return;
            end
            measure(1'b0, 100, c); chk_near($sformatf("bit%0d_low", i), c, 50);
            measure(1'b1, 150, c);
            got_f[i] = (c > 48 * CLK_MHZ);
            chk_near($sformatf("bit%0d_high", i), c, exp_f[i] ? 70 : 27);
        end
        measure(1'b0, 100, c); chk_near("end_low", c, 50);
        repeat (3) @(negedge clk);
        chk("frame_done", done_cnt - d0, 1);
        chk("busy_end", int'(busy), 0);
        for (int k = 0; k < 5; k++)
            chk($sformatf("byte%0d", k), int'(got_f[39 - 8*k -: 8]), int'(exp_f[39 - 8*k -: 8]));
    endtask

    function automatic int WAIT_US();
        return 20;
    endfunction

    initial begin
        int lows, busies;
        host_low    = 1'b0;
        reset_p     = 1'b1;
        humidity    = 8'h00;
        temperature = 8'h00;
        repeat (5) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(frame_done), 0);
        chk("rst_line", int'(dht11_data === 1'b1), 1);
        reset_p = 1'b0;
        wait_us(5);

        do_frame(8'd80, 8'd25, -1, 1'b0);
        do_frame(8'd200, 8'd100, -1, 1'b0);

        // Start pulse too short: sensor must stay silent.
        lows = 0; busies = 0;
        host_low = 1'b1;
        repeat (100 * CLK_MHZ) @(negedge clk) if (busy) busies++;
        host_low = 1'b0;
        repeat (300 * CLK_MHZ) @(negedge clk) begin
            if (dht11_data === 1'b0) lows++;
            if (busy) busies++;
        end
        chk("short_no_drive", lows, 0);
        chk("short_no_busy", busies, 0);

        do_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 20, 1'b0);
        do_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), -1, 1'b0);
        do_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), -1, 1'b1);
        do_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), -1, 1'b0);
        do_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dht11_sensor_emu.md
DHT11_SENSOR_EMU -- requirements
Module: dht11_sensor_emu

Interface
REQ-001 SHALL have parameter CLK_MHZ, default 100, meaning system clock frequency in MHz used to derive the 1 us tick.
REQ-002 SHALL have parameter START_MIN_US, default 18000, meaning minimum host low time in us accepted as a start request.
REQ-003 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-004 SHALL have port reset_p  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port dht11_data  inout  1  open-drain single-wire bus, either driven 0 or released to 'z', never driven 1.
REQ-006 SHALL have port humidity  input  8  integral humidity value to transmit.
REQ-007 SHALL have port temperature  input  8  integral temperature value to transmit.
REQ-008 SHALL have port busy  output  1  high from start acceptance until the end of the frame.
REQ-009 SHALL have port frame_done  output  1  one-cycle pulse when the final 50 us low ends.

Function
REQ-010 SHALL pass dht11_data through a 2-flop synchronizer before any use.
REQ-011 SHALL generate a 1 us tick every CLK_MHZ cycles; all durations are counted in ticks, with a tolerance of +/-1 us.
REQ-012 SHALL use states IDLE, HOST_LOW, WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW.
REQ-013 IDLE: on a synchronized low, go to HOST_LOW and clear the us counter.
REQ-014 HOST_LOW: count low time, saturating at START_MIN_US; on a synchronized high, go to WAIT_RESP if count >= START_MIN_US, otherwise go to IDLE.
REQ-015 On entry to WAIT_RESP, SHALL latch frame = {humidity, 8'h00, temperature, 8'h00, checksum} with checksum = (humidity + temperature) mod 256, and assert busy.
REQ-016 WAIT_RESP SHALL release the line for 20 us, then RESP_LOW SHALL drive 0 for 80 us, then RESP_HIGH SHALL release for 80 us.
REQ-017 Per bit, MSB (frame bit 39) first: BIT_LOW SHALL drive 0 for 50 us, then BIT_HIGH SHALL release for 70 us if the bit is 1 or 27 us if the bit is 0.
REQ-018 A 6-bit bit index SHALL advance after each BIT_HIGH; after bit 0, go to END_LOW.
REQ-019 END_LOW SHALL drive 0 for 50 us, then release the line, pulse frame_done, deassert busy and return to IDLE.
REQ-020 Bus activity from the host SHALL be ignored in every state except IDLE and HOST_LOW; no restart is possible mid-frame.
REQ-021 Changes on humidity/temperature after latching SHALL NOT affect the frame in flight.
REQ-022 A host low held at or beyond saturation SHALL NOT wrap the counter.

Reset
REQ-023 reset_p SHALL asynchronously force state IDLE, release dht11_data ('z'), set busy=0 and frame_done=0, and clear the counters, frame register and synchronizer (both flops to 1).
REQ-024 Reset asserted mid-frame SHALL release the line in the same cycle and abort the frame; the host sees no further edges.

Structure
REQ-025 Package dht11_pkg SHALL hold the state encoding and the timing constants (20, 80, 50, 27, 70 us; frame width 40).
REQ-026 One sub-module, usec_tick_gen (clk, reset_p, tick), SHALL provide the 1 us tick.

Verification
REQ-027 humidity=80, temperature=25, host low 18 ms then release -> line low 20 us later for 80 us, high 80 us, 40 bits decoding to 0x50,0x00,0x19,0x00,0x69, final 50 us low, frame_done pulse.
REQ-028 humidity=200, temperature=100 -> checksum byte 0x2C (wrap).
REQ-029 host low 1 ms then release (START_MIN_US=18000) -> line never driven, busy stays 0.
REQ-030 reset_p asserted during BIT_LOW of bit 20 -> dht11_data 'z' in the same cycle, busy=0, next valid start yields a full correct frame.
REQ-031 host pulls low during RESP_HIGH, humidity changed mid-frame -> frame unchanged and unrestarted.
REQ-032 two back-to-back start requests after frame_done -> two complete, correct frames.
